// File: rtl/cpu_pkg.sv
// cpu_pkg: shared enums and command-field layout for cpu_top_param.
package cpu_pkg;
   typedef enum logic [1:0] {
      MODE_ALU   = 2'd0,
      MODE_STORE = 2'd1,
      MODE_LOAD  = 2'd2,
      MODE_NOP   = 2'd3
   } mode_e;
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_NOT  = 4'd6,
      OP_SHL  = 4'd7,
      OP_SHR  = 4'd8,
      OP_PASS = 4'd9
   } opcode_e;
   typedef enum logic [2:0] {S_IDLE, S_OPS, S_MRD, S_EXEC, S_DONE} state_e;
   // cmd = {mode[1:0], opcode[3:0], sel_a, sel_b}; sel_b sits at bit 0
   function automatic int sel_a_lsb(input int sel_w);
      return sel_w;
   endfunction
   function automatic int op_lsb(input int sel_w);
      return 2 * sel_w;
   endfunction
   function automatic int mode_lsb(input int sel_w);
      return 2 * sel_w + 4;
   endfunction
endpackage

// File: rtl/cpu_mem_sp.sv
// cpu_mem_sp: single-port synchronous RAM with registered read data.
module cpu_mem_sp #(
   parameter int DEPTH = 256,
   parameter int DW = 16,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end
endmodule

// File: rtl/cpu_top_param.sv
// cpu_top_param: single-issue CPU top with generic ALU, accumulator and data memory.
module cpu_top_param
   import cpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_IN = 4,
   parameter int MEM_DEPTH = 256,
   localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
   localparam int SEL_W = $clog2(N_IN + 1),
   localparam int CMD_W = 6 + 2 * SEL_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CMD_W-1:0]      cmd_in,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic                  cmd_valid,
   output logic                  cpu_rdy,
   input  logic [N_IN*WIDTH-1:0] din,
   output logic [2*WIDTH-1:0]    out_reg3,
   output logic                  zero,
   output logic                  error,
   output logic                  done
);
   localparam int DW = 2 * WIDTH;
   localparam int SH_W = $clog2(DW);
   localparam int MODE_L = mode_lsb(SEL_W);
   localparam int OP_L = op_lsb(SEL_W);
   localparam int SA_L = sel_a_lsb(SEL_W);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

   state_e state_q, state_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a_sel, b_sel;
   logic [DW-1:0] acc_q, acc_d, alu_r, rdata, a_x, b_x;
   logic zero_q, zero_d, err_q, err_d, mem_we;
   mode_e mode, mode_in;
   logic [3:0] op;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic sel_bad, op_bad, addr_bad;

   assign mode = mode_e'(cmd_q[MODE_L +: 2]);
   assign mode_in = mode_e'(cmd_in[MODE_L +: 2]);
   assign op = cmd_q[OP_L +: 4];
   assign sel_a = cmd_q[SA_L +: SEL_W];
   assign sel_b = cmd_q[SEL_W-1:0];
   assign sel_bad = (sel_a > SEL_W'(N_IN)) || (sel_b > SEL_W'(N_IN));
   assign op_bad = op > OP_PASS;
   assign addr_bad = {1'b0, addr_q} >= DEPTH_C;

   cpu_mem_sp #(.DEPTH(MEM_DEPTH), .DW(DW)) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .addr_i  (addr_q),
      .wdata_i (acc_q),
      .rdata_o (rdata)
   );

   // sel == N_IN (or any unmatched value) falls through to the accumulator low half
   always_comb begin
      a_sel = acc_q[WIDTH-1:0];
      b_sel = acc_q[WIDTH-1:0];
      for (int k = 0; k < N_IN; k++) begin
         if (sel_a == SEL_W'(k)) a_sel = din[k*WIDTH +: WIDTH];
         if (sel_b == SEL_W'(k)) b_sel = din[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      a_x = {{WIDTH{1'b0}}, a_q};
      b_x = {{WIDTH{1'b0}}, b_q};
      case (op)
         OP_ADD:  alu_r = a_x + b_x;
         OP_SUB:  alu_r = a_x - b_x;
         OP_MUL:  alu_r = a_x * b_x;
         OP_AND:  alu_r = a_x & b_x;
         OP_OR:   alu_r = a_x | b_x;
         OP_XOR:  alu_r = a_x ^ b_x;
         OP_NOT:  alu_r = {{WIDTH{1'b0}}, ~a_q};
         OP_SHL:  alu_r = a_x << b_q[SH_W-1:0];
         OP_SHR:  alu_r = a_x >> b_q[SH_W-1:0];
         default: alu_r = a_x;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cmd_d = cmd_q;
      addr_d = addr_q;
      a_d = a_q;
      b_d = b_q;
      acc_d = acc_q;
      zero_d = zero_q;
      err_d = err_q;
      mem_we = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            cmd_d = cmd_in;
            addr_d = cmd_addr;
            state_d = (mode_in == MODE_ALU) ? S_OPS :
                      (mode_in == MODE_LOAD) ? S_MRD :
                      (mode_in == MODE_STORE) ? S_EXEC : S_DONE;
         end
         S_OPS: begin
            a_d = a_sel;
            b_d = b_sel;
            state_d = S_EXEC;
         end
         S_MRD: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_DONE;
            if (mode == MODE_ALU) begin
               if (op_bad || sel_bad) err_d = 1'b1;
               else begin
                  acc_d = alu_r;
                  zero_d = alu_r == '0;
                  err_d = 1'b0;
               end
            end else if (addr_bad) err_d = 1'b1;
            else if (mode == MODE_LOAD) begin
               acc_d = rdata;
               zero_d = rdata == '0;
               err_d = 1'b0;
            end else mem_we = !reset;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         acc_q <= '0;
         zero_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q <= acc_d;
         zero_q <= zero_d;
         err_q <= err_d;
      end
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      a_q <= a_d;
      b_q <= b_d;
   end

   assign cpu_rdy = state_q == S_IDLE;
   assign done = state_q == S_DONE;
   assign out_reg3 = acc_q;
   assign zero = zero_q;
   assign error = err_q;
endmodule

// File: tb/tb_cpu_top_param.sv
// tb_cpu_top_param: directed self-checking bench for cpu_top_param (WIDTH=8, N_IN=4).
module tb_cpu_top_param;
   import cpu_pkg::*;
   logic clk = 1'b0;
   logic reset, cmd_valid, cpu_rdy, zero, error, done;
   logic [11:0] cmd_in;
   logic [7:0] cmd_addr;
   logic [31:0] din;
   logic [15:0] out_reg3;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string tag;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [15:0] r;
      logic z;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;

   cpu_top_param #(.WIDTH(8), .N_IN(4), .MEM_DEPTH(256)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_in    (cmd_in),
      .cmd_addr  (cmd_addr),
      .cmd_valid (cmd_valid),
      .cpu_rdy   (cpu_rdy),
      .din       (din),
      .out_reg3  (out_reg3),
      .zero      (zero),
      .error     (error),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // garbage on cmd_in with valid held high while busy must not be latched or re-accepted
   task automatic issue(input logic [1:0] m, input logic [3:0] op, input logic [2:0] sa,
                        input logic [2:0] sb, input logic [7:0] ad, output int lt);
      cmd_in = {m, op, sa, sb};
      cmd_addr = ad;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_in = '1;
      cmd_addr = '1;
      lt = 1;
      while (!done && lt < 20) begin
         @(posedge clk); #1;
         lt++;
      end
      cmd_valid = 1'b0;
      check("rdy_in_done", cpu_rdy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("rdy_after_done", cpu_rdy, 1);
   endtask

   task automatic run(input string tag, input logic [1:0] m, input logic [3:0] op,
                      input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] ad,
                      input logic [15:0] ea, input logic ez, input logic ee, input int el);
      int lt;
      issue(m, op, sa, sb, ad, lt);
      check({tag, "_lat"}, lt, el);
      check({tag, "_acc"}, out_reg3, ea);
      check({tag, "_zero"}, zero, ez);
      check({tag, "_err"}, error, ee);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{"add",     4'd0, 8'd200, 8'd100, 16'h012C, 1'b0};
      tbl[1]  = '{"sub",     4'd1, 8'd5,   8'd7,   16'hFFFE, 1'b0};
      tbl[2]  = '{"mul",     4'd2, 8'd255, 8'd255, 16'hFE01, 1'b0};
      tbl[3]  = '{"and",     4'd3, 8'hF0,  8'h3C,  16'h0030, 1'b0};
      tbl[4]  = '{"or",      4'd4, 8'hF0,  8'h3C,  16'h00FC, 1'b0};
      tbl[5]  = '{"xor",     4'd5, 8'h5A,  8'h5A,  16'h0000, 1'b1};
      tbl[6]  = '{"not",     4'd6, 8'h0F,  8'h00,  16'h00F0, 1'b0};
      tbl[7]  = '{"shl4",    4'd7, 8'h81,  8'h04,  16'h0810, 1'b0};
      tbl[8]  = '{"shr4",    4'd8, 8'h81,  8'h04,  16'h0008, 1'b0};
      tbl[9]  = '{"shl15",   4'd7, 8'h81,  8'h0F,  16'h8000, 1'b0};
      tbl[10] = '{"pass",    4'd9, 8'h12,  8'h00,  16'h0012, 1'b0};
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_in = '0;
      cmd_addr = '0;
      din = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_acc", out_reg3, 0);
      check("rst_zero", zero, 0);
      check("rst_err", error, 0);
      check("rst_done", done, 0);
      check("rst_rdy", cpu_rdy, 1);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         din = {8'd0, 8'd3, tbl[i].b, tbl[i].a};
         run(tbl[i].tag, 2'b00, tbl[i].op, 3'd0, 3'd1, 8'd0, tbl[i].r, tbl[i].z, 1'b0, 3);
      end
      run("acc_fb", 2'b00, 4'd0, 3'd4, 3'd2, 8'd0, 16'h0015, 1'b0, 1'b0, 3);

      din = {8'd0, 8'd3, 8'd255, 8'd255};
      run("mul2", 2'b00, 4'd2, 3'd0, 3'd1, 8'd0, 16'hFE01, 1'b0, 1'b0, 3);
      run("st10", 2'b01, 4'd0, 3'd0, 3'd0, 8'h10, 16'hFE01, 1'b0, 1'b0, 2);
      run("xor0", 2'b00, 4'd5, 3'd0, 3'd0, 8'd0, 16'h0000, 1'b1, 1'b0, 3);
      run("st20", 2'b01, 4'd0, 3'd0, 3'd0, 8'h20, 16'h0000, 1'b1, 1'b0, 2);
      run("ld20", 2'b10, 4'd0, 3'd0, 3'd0, 8'h20, 16'h0000, 1'b1, 1'b0, 3);
      run("ld10", 2'b10, 4'd0, 3'd0, 3'd0, 8'h10, 16'hFE01, 1'b0, 1'b0, 3);
      run("illop", 2'b00, 4'd12, 3'd0, 3'd1, 8'd0, 16'hFE01, 1'b0, 1'b1, 3);
      run("badsel", 2'b00, 4'd0, 3'd5, 3'd1, 8'd0, 16'hFE01, 1'b0, 1'b1, 3);
      run("st_keep", 2'b01, 4'd0, 3'd0, 3'd0, 8'h30, 16'hFE01, 1'b0, 1'b1, 2);
      run("nop", 2'b11, 4'd0, 3'd0, 3'd0, 8'd0, 16'hFE01, 1'b0, 1'b1, 1);
      din = {8'd0, 8'd3, 8'd2, 8'd1};
      run("clr_err", 2'b00, 4'd0, 3'd0, 3'd1, 8'd0, 16'h0003, 1'b0, 1'b0, 3);
      run("illop15", 2'b00, 4'd15, 3'd0, 3'd1, 8'd0, 16'h0003, 1'b0, 1'b1, 3);

      cmd_in = {2'b00, 4'd0, 3'd0, 3'd1};
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("ops_busy", cpu_rdy, 0);
      reset = 1'b1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rops_acc", out_reg3, 0);
      check("rops_zero", zero, 0);
      check("rops_err", error, 0);
      check("rops_rdy", cpu_rdy, 1);
      check("rops_done", done, 0);

      run("acc3", 2'b00, 4'd0, 3'd0, 3'd1, 8'd0, 16'h0003, 1'b0, 1'b0, 3);
      cmd_in = {2'b01, 4'd0, 3'd0, 3'd0};
      cmd_addr = 8'h10;
      cmd_valid = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cmd_valid = 1'b0;
      check("rst_st_rdy", cpu_rdy, 1);
      check("rst_st_acc", out_reg3, 0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_st_idle", cpu_rdy, 1);
      run("ld10_keep", 2'b10, 4'd0, 3'd0, 3'd0, 8'h10, 16'hFE01, 1'b0, 1'b0, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
